// File: rtl/regfile_fwd_param.sv
// rtl/regfile_fwd_param.sv - parametrised ID-stage register bank with forwarding, bypass and clear engine
// Registered reads, hardwired R0 option, sequential post-reset clear with busy and dropped-write flags.
module regfile_fwd_param #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 5,
   parameter int NUM_RD  = 2,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          rw,
   input  logic [DATA_W-1:0]          wdata,
   input  logic [NUM_RD*ADDR_W-1:0]   ra,
   input  logic [NUM_RD*2-1:0]        fwd_sel,
   input  logic [DATA_W-1:0]          ans_ex,
   input  logic [DATA_W-1:0]          ans_dm,
   input  logic [DATA_W-1:0]          ans_wb,
   input  logic [DATA_W-1:0]          imm,
   input  logic                       imm_sel,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic                       busy,
   output logic                       wr_drop
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

   typedef enum logic {ST_CLEAR, ST_RUN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              busy_q, busy_d;
   logic              wr_drop_q, wr_drop_d;
   logic [DATA_W-1:0] latch_q [NUM_RD];
   logic [DATA_W-1:0] latch_d [NUM_RD];
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] ra_port [NUM_RD];

   logic              mem_we;
   logic [ADDR_W-1:0] mem_wa;
   logic [DATA_W-1:0] mem_wd;
   logic              wr_zero;

   for (genvar g = 0; g < NUM_RD; g++) begin : g_ra
      assign ra_port[g] = ra[g*ADDR_W +: ADDR_W];
   end

   // Writes aimed at a hardwired-zero R0 are silently discarded.
   assign wr_zero = R0_ZERO && (rw == '0);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      busy_d    = busy_q;
      wr_drop_d = 1'b0;
      mem_we    = 1'b0;
      mem_wa    = rw;
      mem_wd    = wdata;
      for (int i = 0; i < NUM_RD; i++) begin
         latch_d[i] = '0;
      end
      if (rst) begin
         state_d = ST_CLEAR;
         ptr_d   = '0;
         busy_d  = 1'b1;
      end else if (state_q == ST_CLEAR) begin
         mem_we    = 1'b1;
         mem_wa    = ptr_q;
         mem_wd    = '0;
         ptr_d     = ptr_q + 1'b1;
         wr_drop_d = we;
         if (ptr_q == LAST_ADDR) begin
            state_d = ST_RUN;
            busy_d  = 1'b0;
         end
      end else begin
         mem_we = we && !wr_zero;
         for (int i = 0; i < NUM_RD; i++) begin
            if (R0_ZERO && (ra_port[i] == '0)) begin
               latch_d[i] = '0;
            end else if (we && (rw == ra_port[i])) begin
               latch_d[i] = wdata;
            end else begin
               latch_d[i] = mem_q[ra_port[i]];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      busy_q    <= busy_d;
      wr_drop_q <= wr_drop_d;
      for (int i = 0; i < NUM_RD; i++) begin
         latch_q[i] <= latch_d[i];
      end
      if (mem_we) begin
         mem_q[mem_wa] <= mem_wd;
      end
   end

   // Forwarding sits after the latches so it stays live while the clear runs.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         case (fwd_sel[i*2 +: 2])
            2'b00:   rd_data[i*DATA_W +: DATA_W] = latch_q[i];
            2'b01:   rd_data[i*DATA_W +: DATA_W] = ans_ex;
            2'b10:   rd_data[i*DATA_W +: DATA_W] = ans_dm;
            default: rd_data[i*DATA_W +: DATA_W] = ans_wb;
         endcase
         if ((i == 1) && imm_sel) begin
            rd_data[i*DATA_W +: DATA_W] = imm;
         end
      end
   end

   assign busy    = busy_q;
   assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_fwd_param.sv
// tb/tb_regfile_fwd_param.sv - directed self-checking bench for regfile_fwd_param
// Instance a uses default parameters; instance b uses NUM_RD=3, DATA_W=32, ADDR_W=4.
module tb_regfile_fwd_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Instance a: defaults
   logic        rst, we, imm_sel;
   logic [4:0]  rw;
   logic [15:0] wdata, ans_ex, ans_dm, ans_wb, imm;
   logic [9:0]  ra;
   logic [3:0]  fwd_sel;
   logic [31:0] rd_data;
   logic        busy, wr_drop;

   // Instance b: 3 ports, 32-bit, 16 deep
   logic        b_rst, b_we, b_imm_sel;
   logic [3:0]  b_rw;
   logic [31:0] b_wdata, b_ans_ex, b_ans_dm, b_ans_wb, b_imm;
   logic [11:0] b_ra;
   logic [5:0]  b_fwd_sel;
   logic [95:0] b_rd_data;
   logic        b_busy, b_wr_drop;

   regfile_fwd_param u_dut_a (
      .clk(clk), .rst(rst), .we(we), .rw(rw), .wdata(wdata), .ra(ra),
      .fwd_sel(fwd_sel), .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb),
      .imm(imm), .imm_sel(imm_sel), .rd_data(rd_data), .busy(busy), .wr_drop(wr_drop)
   );

   regfile_fwd_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .R0_ZERO(1'b1)) u_dut_b (
      .clk(clk), .rst(b_rst), .we(b_we), .rw(b_rw), .wdata(b_wdata), .ra(b_ra),
      .fwd_sel(b_fwd_sel), .ans_ex(b_ans_ex), .ans_dm(b_ans_dm), .ans_wb(b_ans_wb),
      .imm(b_imm), .imm_sel(b_imm_sel), .rd_data(b_rd_data), .busy(b_busy), .wr_drop(b_wr_drop)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_a(input logic [4:0] addr, input logic [15:0] data);
      we = 1'b1; rw = addr; wdata = data;
      tick();
      we = 1'b0;
   endtask

   task automatic rd_a(input logic [4:0] addr);
      ra = {addr, addr};
      tick();
   endtask

   task automatic wait_idle_a(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_idle_b(output int n);
      n = 0;
      while (b_busy === 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   int cyc;

   initial begin
      rst = 1'b1; we = 1'b0; rw = '0; wdata = '0; ra = '0; fwd_sel = '0;
      ans_ex = '0; ans_dm = '0; ans_wb = '0; imm = '0; imm_sel = 1'b0;
      b_rst = 1'b1; b_we = 1'b0; b_rw = '0; b_wdata = '0; b_ra = '0; b_fwd_sel = '0;
      b_ans_ex = '0; b_ans_dm = '0; b_ans_wb = '0; b_imm = '0; b_imm_sel = 1'b0;

      // Reset state and clear duration
      tick();
      check_eq("busy_rst", 64'(busy), 64'd1);
      check_eq("wr_drop_rst", 64'(wr_drop), 64'd0);
      check_eq("rd_data_rst", 64'(rd_data), 64'd0);
      rst = 1'b0;
      wait_idle_a(cyc);
      check_eq("clear_cycles", 64'(cyc), 64'd32);
      for (int i = 0; i < 32; i++) begin
         rd_a(5'(i));
         check_eq($sformatf("clr_rd_a_%0d", i), 64'(rd_data[15:0]), 64'd0);
         check_eq($sformatf("clr_rd_b_%0d", i), 64'(rd_data[31:16]), 64'd0);
      end

      // Write then read
      wr_a(5'd7, 16'hBEEF);
      ra = {5'd0, 5'd7};
      tick();
      check_eq("wr_rd_r7", 64'(rd_data[15:0]), 64'hBEEF);

      // Bypass on port 1
      we = 1'b1; rw = 5'd9; wdata = 16'h1234; ra = {5'd9, 5'd0};
      tick();
      we = 1'b0;
      check_eq("bypass_b", 64'(rd_data[31:16]), 64'h1234);
      check_eq("bypass_a_r0", 64'(rd_data[15:0]), 64'h0000);

      // R0 write discarded, including through the bypass
      we = 1'b1; rw = 5'd0; wdata = 16'hFFFF; ra = {5'd0, 5'd0};
      tick();
      we = 1'b0;
      check_eq("r0_bypass", 64'(rd_data[15:0]), 64'h0000);
      rd_a(5'd0);
      check_eq("r0_read", 64'(rd_data[15:0]), 64'h0000);

      // Same address on both ports; back-to-back writes
      wr_a(5'd6, 16'hAAAA);
      wr_a(5'd6, 16'h5555);
      rd_a(5'd6);
      check_eq("b2b_a", 64'(rd_data[15:0]), 64'h5555);
      check_eq("b2b_b", 64'(rd_data[31:16]), 64'h5555);

      // Forwarding and immediate override
      ans_ex = 16'h0A0A; ans_dm = 16'h0C0C; ans_wb = 16'h0B0B; imm = 16'h0042;
      fwd_sel = {2'b11, 2'b01};
      #1;
      check_eq("fwd_a_ex", 64'(rd_data[15:0]), 64'h0A0A);
      check_eq("fwd_b_wb", 64'(rd_data[31:16]), 64'h0B0B);
      fwd_sel = {2'b10, 2'b10};
      #1;
      check_eq("fwd_a_dm", 64'(rd_data[15:0]), 64'h0C0C);
      check_eq("fwd_b_dm", 64'(rd_data[31:16]), 64'h0C0C);
      imm_sel = 1'b1;
      #1;
      check_eq("imm_b", 64'(rd_data[31:16]), 64'h0042);
      check_eq("imm_a_kept", 64'(rd_data[15:0]), 64'h0C0C);
      imm_sel = 1'b0; fwd_sel = '0;

      // Write during clear; forwarding live but register path zero
      rst = 1'b1;
      tick();
      rst = 1'b0;
      ra = {5'd9, 5'd7};
      tick();
      check_eq("clr_latch_zero", 64'(rd_data[31:16]), 64'h0000);
      fwd_sel = 4'b0001;
      #1;
      check_eq("clr_fwd_ex", 64'(rd_data[15:0]), 64'h0A0A);
      fwd_sel = '0;
      tick(); tick(); tick();
      we = 1'b1; rw = 5'd3; wdata = 16'h5A5A;
      tick();
      we = 1'b0;
      check_eq("wr_drop_pulse", 64'(wr_drop), 64'd1);
      tick();
      check_eq("wr_drop_clear", 64'(wr_drop), 64'd0);
      wait_idle_a(cyc);
      check_eq("clear_after_drop", 64'(cyc + 6), 64'd32);
      rd_a(5'd3);
      check_eq("dropped_r3", 64'(rd_data[15:0]), 64'h0000);
      rd_a(5'd9);
      check_eq("cleared_r9", 64'(rd_data[15:0]), 64'h0000);

      // Reset mid-clear restarts the pointer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      check_eq("busy_mid_clear", 64'(busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_idle_a(cyc);
      check_eq("restart_clear_cycles", 64'(cyc), 64'd32);

      // Reset mid-run wipes a full bank
      for (int i = 1; i < 32; i++) wr_a(5'(i), 16'hA000 | 16'(i));
      rd_a(5'd1);
      check_eq("fill_r1", 64'(rd_data[15:0]), 64'hA001);
      rd_a(5'd31);
      check_eq("fill_r31", 64'(rd_data[31:16]), 64'hA01F);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wait_idle_a(cyc);
      check_eq("run_rst_clear_cycles", 64'(cyc), 64'd32);
      for (int i = 1; i < 32; i++) begin
         rd_a(5'(i));
         check_eq($sformatf("wipe_r%0d", i), 64'(rd_data[15:0]), 64'd0);
      end

      // Instance b: 3 ports, 32-bit data, 16-deep clear
      tick();
      check_eq("b_busy_rst", 64'(b_busy), 64'd1);
      b_rst = 1'b0;
      wait_idle_b(cyc);
      check_eq("b_clear_cycles", 64'(cyc), 64'd16);
      b_we = 1'b1; b_rw = 4'd15; b_wdata = 32'hDEADBEEF;
      tick();
      b_we = 1'b0;
      b_ra = {4'd15, 4'd0, 4'd15};
      tick();
      check_eq("b_p2_r15", 64'(b_rd_data[95:64]), 64'hDEADBEEF);
      check_eq("b_p0_r15", 64'(b_rd_data[31:0]), 64'hDEADBEEF);
      check_eq("b_p1_r0", 64'(b_rd_data[63:32]), 64'h0);
      b_we = 1'b1; b_rw = 4'd4; b_wdata = 32'h8765_4321; b_ra = {4'd4, 4'd0, 4'd0};
      tick();
      b_we = 1'b0;
      check_eq("b_bypass_p2", 64'(b_rd_data[95:64]), 64'h8765_4321);
      b_ans_wb = 32'hCAFE_F00D; b_imm = 32'h1357_9BDF; b_fwd_sel = 6'b11_00_00; b_imm_sel = 1'b1;
      #1;
      check_eq("b_fwd_p2_wb", 64'(b_rd_data[95:64]), 64'hCAFE_F00D);
      check_eq("b_imm_p1", 64'(b_rd_data[63:32]), 64'h1357_9BDF);
      b_fwd_sel = '0; b_imm_sel = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
